// File: rtl/rhs_spi_responder_if.sv
// SPI bus between the rhs_256 master and an RHS2116-style responder.
// The master drives sclk/cs/mosi and the responder drives miso.
interface rhs_spi_responder_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/rhs_spi_responder.sv
// RHS2116-style SPI responder for HIL loopback of rhs_256. SPI pins are oversampled on clk.
// 32-bit commands are decoded, and each response is returned two frames later.
//   state | meaning
//   IDLE  | cs high, waiting for a cs falling edge
//   SHIFT | cs low, fewer than 32 bits received
//   HOLD  | cs low, full frame decoded, extra sclk edges ignored
module rhs_spi_responder #(
  parameter logic [15:0] STARTING_SEED = 16'd0,
  parameter int          NUM_REGS      = 16,
  parameter logic [15:0] CHIP_ID       = 16'h0020
) (
  input  logic                clk,
  input  logic                rstn,
  rhs_spi_responder_if.slave  spi,
  output logic [5:0]          channel_out,
  output logic                frame_done,
  output logic                frame_abort
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sclk_s1_q, sclk_s2_q, sclk_e_q;
  logic cs_s1_q, cs_s2_q, cs_e_q;
  logic mosi_s1_q, mosi_s2_q;

  // cs sync flops reset low, so a cs already low at reset release never reads as a new frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_e_q  <= 1'b0;
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      cs_e_q    <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= spi.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_e_q  <= sclk_s2_q;
      cs_s1_q   <= spi.cs;
      cs_s2_q   <= cs_s1_q;
      cs_e_q    <= cs_s2_q;
      mosi_s1_q <= spi.mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s2_q & ~sclk_e_q;
  assign sclk_fall = ~sclk_s2_q & sclk_e_q;
  assign cs_fall   = ~cs_s2_q & cs_e_q;
  assign cs_rise   = cs_s2_q & ~cs_e_q;

  logic [1:0]  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] rx_shift_q, rx_shift_d;
  logic [31:0] tx_shift_q, tx_shift_d;
  logic        miso_q, miso_d;
  logic [31:0] stage1_q, stage1_d;
  logic [31:0] stage2_q, stage2_d;
  logic [15:0] conv_count_q, conv_count_d;
  logic [5:0]  channel_q, channel_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_abort_q, frame_abort_d;
  logic [15:0] regs_q [NUM_REGS];
  logic [15:0] regs_d [NUM_REGS];

  logic [31:0] cmd, rsp;
  logic [7:0]  addr;
  logic        addr_ok, decode;
  logic [5:0]  bits_seen;
  logic        unused_cmd_bits;

  assign cmd             = {rx_shift_q[30:0], mosi_s2_q};
  assign addr            = cmd[23:16];
  assign addr_ok         = {1'b0, addr} < 9'(NUM_REGS);
  assign decode          = (state_q == ST_SHIFT) && sclk_rise && (bit_cnt_q == 6'd31);
  assign bits_seen       = sclk_rise ? bit_cnt_q + 6'd1 : bit_cnt_q;
  // command bits with no meaning to this responder
  assign unused_cmd_bits = ^{rx_shift_q[31], cmd[29:24]};

  always_comb begin
    rsp = 32'h0;
    case (cmd[31:30])
      2'b00: rsp = {STARTING_SEED + {10'd0, cmd[21:16]}, conv_count_q};
      2'b10: rsp = {16'hFFFF, cmd[15:0]};
      2'b11: begin
        if (addr_ok)             rsp = {16'h0000, regs_q[addr[AW-1:0]]};
        else if (addr == 8'hFF)  rsp = {16'h0000, CHIP_ID};
      end
      default: rsp = 32'h0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    stage1_d      = stage1_q;
    stage2_d      = stage2_q;
    conv_count_d  = conv_count_q;
    channel_d     = channel_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    regs_d        = regs_q;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = 6'd0;
          rx_shift_d = 32'h0;
          tx_shift_d = stage2_q;
          miso_d     = stage2_q[31];
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = cmd;
          bit_cnt_d  = bit_cnt_q + 6'd1;
          if (decode) begin
            state_d      = ST_HOLD;
            miso_d       = 1'b0;
            tx_shift_d   = 32'h0;
            stage2_d     = stage1_q;
            stage1_d     = rsp;
            frame_done_d = 1'b1;
            if (cmd[31:30] == 2'b00) begin
              conv_count_d = conv_count_q + 16'd1;
              channel_d    = cmd[21:16];
            end
            if (cmd[31:30] == 2'b10 && addr_ok) regs_d[addr[AW-1:0]] = cmd[15:0];
          end
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[30:0], 1'b0};
          miso_d     = tx_shift_q[30];
        end
        // a frame finishing in the same cycle as cs_rise is a completed frame, not an abort
        if (cs_rise) begin
          state_d       = ST_IDLE;
          bit_cnt_d     = 6'd0;
          rx_shift_d    = 32'h0;
          miso_d        = 1'b0;
          frame_abort_d = !decode && (bits_seen != 6'd0);
        end
      end
      ST_HOLD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = 6'd0;
          rx_shift_d = 32'h0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 6'd0;
      rx_shift_q    <= 32'h0;
      tx_shift_q    <= 32'h0;
      miso_q        <= 1'b0;
      stage1_q      <= 32'h0;
      stage2_q      <= 32'h0;
      conv_count_q  <= 16'd0;
      channel_q     <= 6'd0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'h0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      stage1_q      <= stage1_d;
      stage2_q      <= stage2_d;
      conv_count_q  <= conv_count_d;
      channel_q     <= channel_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      regs_q        <= regs_d;
    end
  end

  assign spi.miso    = miso_q;
  assign channel_out = channel_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
endmodule

// File: tb/tb_rhs_spi_responder.sv
// Directed bench for rhs_spi_responder: a behavioural SPI master at SCLK = clk/4 and
// hand-computed MISO words for the two-frame response pipeline.
module tb_rhs_spi_responder;
  localparam int H = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] channel_out;
  logic       frame_done, frame_abort;
  int         errors = 0, checks = 0, done_cnt = 0, abort_cnt = 0;

  always #5 clk = ~clk;

  rhs_spi_responder_if spi_if ();

  rhs_spi_responder #(.STARTING_SEED(16'd16), .NUM_REGS(16), .CHIP_ID(16'h0020)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .spi         (spi_if),
    .channel_out (channel_out),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always @(negedge clk) if (rstn) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_if.mosi = b;
    #H;
    spi_if.sclk = 1'b1;
    #(H - 1);
    m = spi_if.miso;
    #1;
    spi_if.sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] cmd, input int nbits, output logic [31:0] rsp);
    logic m;
    rsp = 32'h0;
    spi_if.cs = 1'b0;
    #(2 * H);
    for (int i = 31; i >= 32 - nbits; i--) begin
      spi_bit(cmd[i], m);
      rsp[i] = m;
    end
    #H;
    spi_if.cs   = 1'b1;
    spi_if.mosi = 1'b0;
    #(2 * H);
  endtask

  task automatic apply_reset();
    spi_if.cs   = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  task automatic test_reset();
    spi_if.cs   = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (spi_if.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_if.miso); end
    checks++; if (channel_out !== 6'd0) begin errors++; $display("FAIL reset_channel: got %0d expected 0", channel_out); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", frame_abort); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_convert();
    logic [31:0] r [3];
    apply_reset();
    for (int n = 0; n < 3; n++) spi_frame(32'h0005_0000, 32, r[n]);
    checks++; if (r[0] !== 32'h0) begin errors++; $display("FAIL conv_f1: got %h expected 00000000", r[0]); end
    checks++; if (r[1] !== 32'h0) begin errors++; $display("FAIL conv_f2: got %h expected 00000000", r[1]); end
    checks++; if (r[2] !== 32'h0015_0000) begin errors++; $display("FAIL conv_f3: got %h expected 00150000", r[2]); end
    checks++; if (channel_out !== 6'd5) begin errors++; $display("FAIL conv_channel: got %0d expected 5", channel_out); end
    checks++; if (done_cnt !== 3) begin errors++; $display("FAIL conv_done_cnt: got %0d expected 3", done_cnt); end
  endtask

  task automatic test_write_read();
    logic [31:0] r [4];
    apply_reset();
    spi_frame(32'h8003_BEEF, 32, r[0]);
    spi_frame(32'hC003_0000, 32, r[1]);
    spi_frame(32'h0000_0000, 32, r[2]);
    spi_frame(32'h0000_0000, 32, r[3]);
    checks++; if (r[2] !== 32'hFFFF_BEEF) begin errors++; $display("FAIL wr_echo: got %h expected ffffbeef", r[2]); end
    checks++; if (r[3] !== 32'h0000_BEEF) begin errors++; $display("FAIL rd_reg3: got %h expected 0000beef", r[3]); end
  endtask

  task automatic test_chip_id();
    logic [31:0] r [6];
    apply_reset();
    spi_frame(32'hC0FF_0000, 32, r[0]);
    spi_frame(32'hC0C8_0000, 32, r[1]);
    spi_frame(32'h80C8_1234, 32, r[2]);
    spi_frame(32'hC008_0000, 32, r[3]);
    spi_frame(32'h0000_0000, 32, r[4]);
    spi_frame(32'h0000_0000, 32, r[5]);
    checks++; if (r[2] !== 32'h0000_0020) begin errors++; $display("FAIL chip_id: got %h expected 00000020", r[2]); end
    checks++; if (r[3] !== 32'h0000_0000) begin errors++; $display("FAIL rd_200: got %h expected 00000000", r[3]); end
    checks++; if (r[4] !== 32'hFFFF_1234) begin errors++; $display("FAIL wr_200_echo: got %h expected ffff1234", r[4]); end
    checks++; if (r[5] !== 32'h0000_0000) begin errors++; $display("FAIL rd_reg8_after_wr200: got %h expected 00000000", r[5]); end
  endtask

  task automatic test_abort();
    logic [31:0] r [6];
    apply_reset();
    spi_frame(32'h0001_0000, 32, r[0]);
    spi_frame(32'h8001_FFFF, 17, r[1]);
    spi_frame(32'h0002_0000, 32, r[2]);
    spi_frame(32'h0003_0000, 32, r[3]);
    spi_frame(32'h0009_0000, 32, r[4]);
    spi_frame(32'h0000_0000, 0, r[5]);
    checks++; if (abort_cnt !== 1) begin errors++; $display("FAIL abort_cnt: got %0d expected 1", abort_cnt); end
    checks++; if (done_cnt !== 4) begin errors++; $display("FAIL abort_done_cnt: got %0d expected 4", done_cnt); end
    checks++; if (r[3] !== 32'h0011_0000) begin errors++; $display("FAIL abort_pipe_a: got %h expected 00110000", r[3]); end
    checks++; if (r[4] !== 32'h0012_0001) begin errors++; $display("FAIL abort_pipe_b: got %h expected 00120001", r[4]); end
    checks++; if (channel_out !== 6'd9) begin errors++; $display("FAIL abort_channel: got %0d expected 9", channel_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r [32];
    logic [31:0] exp;
    logic [15:0] k;
    apply_reset();
    for (int n = 0; n < 32; n++) spi_frame(32'(n) << 16, 32, r[n]);
    for (int n = 0; n < 32; n++) begin
      k   = 16'(n - 2);
      exp = (n < 2) ? 32'h0 : {16'd16 + k, k};
      checks++;
      if (r[n] !== exp) begin errors++; $display("FAIL sweep_frame%0d: got %h expected %h", n, r[n], exp); end
    end
    checks++; if (done_cnt !== 32) begin errors++; $display("FAIL sweep_done_cnt: got %0d expected 32", done_cnt); end
    checks++; if (channel_out !== 6'd31) begin errors++; $display("FAIL sweep_channel: got %0d expected 31", channel_out); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] cmd = 32'h8001_1234;
    logic [31:0] r [4];
    logic m;
    apply_reset();
    spi_if.cs = 1'b0;
    #(2 * H);
    for (int i = 31; i >= 20; i--) spi_bit(cmd[i], m);
    rstn = 1'b0;
    #30;
    rstn = 1'b1;
    #20;
    for (int i = 19; i >= 0; i--) spi_bit(cmd[i], m);
    #H;
    spi_if.cs = 1'b1;
    #(2 * H);
    spi_frame(32'hC001_0000, 32, r[0]);
    spi_frame(32'h8001_5678, 32, r[1]);
    spi_frame(32'h0000_0000, 32, r[2]);
    spi_frame(32'h0000_0000, 32, r[3]);
    checks++; if (r[2] !== 32'h0000_0000) begin errors++; $display("FAIL rst_mid_reg1: got %h expected 00000000", r[2]); end
    checks++; if (r[3] !== 32'hFFFF_5678) begin errors++; $display("FAIL rst_mid_next_frame: got %h expected ffff5678", r[3]); end
    checks++; if (done_cnt !== 4) begin errors++; $display("FAIL rst_mid_done_cnt: got %0d expected 4", done_cnt); end
    checks++; if (abort_cnt !== 0) begin errors++; $display("FAIL rst_mid_abort_cnt: got %0d expected 0", abort_cnt); end
  endtask

  initial begin
    spi_if.cs   = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    @(negedge clk);
    test_reset();
    test_convert();
    test_write_read();
    test_chip_id();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
